// File: rtl/muldiv_hilo.sv
// muldiv_hilo: sequential multiply/divide unit owning the HI/LO pair.
// Resolves one result bit per cycle: shift-add for MULT/MULTU and a
// restoring step for DIV/DIVU. The sign of the result is applied in a
// single fix-up cycle. MTHI/MTLO write HI/LO directly while idle.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start, op     launch: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (idle only)
//   x, y          multiplicand/dividend, multiplier/divisor (latched on start)
//   wr_hi, wr_lo  MTHI/MTLO strobes, write wdata (idle only)
//   wdata         MTHI/MTLO data
//   busy          operation in flight
//   done          one-cycle pulse when HI/LO take a result
//   hi, lo        product[2W-1:W]/product[W-1:0], or remainder/quotient
module muldiv_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             st;
    logic               is_div;
    logic               div0;
    logic               neg_q;     // product / quotient must be negated
    logic               neg_r;     // remainder takes the dividend's sign
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mag_x;     // |x|, or raw x for a divide by zero
    logic [WIDTH-1:0]   mag_y;     // |y| (divisor)
    // Multiply: {partial high, multiplier shifting out}.
    // Divide:   low half holds dividend shifting out, quotient shifting in.
    logic [2*WIDTH-1:0] acc;
    // Remainder always stays below the divisor, so WIDTH bits hold it;
    // the shifted trial value carries the extra bit.
    logic [WIDTH-1:0]   rem;

    logic               sgn, x_neg, y_neg;
    logic [WIDTH-1:0]   x_abs, y_abs;
    logic [WIDTH:0]     m_sum;
    logic [2*WIDTH-1:0] acc_mul;
    logic [WIDTH:0]     shifted;
    logic               take;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] acc_div;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rmd;

    always_comb begin
        sgn   = ~op[0];
        x_neg = sgn & x[WIDTH-1];
        y_neg = sgn & y[WIDTH-1];
        x_abs = x_neg ? -x : x;
        y_abs = y_neg ? -y : y;

        // Shift-add: add multiplicand when the multiplier LSB is set, then
        // shift the whole accumulator (with carry) right by one.
        m_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_x} : '0);
        acc_mul = {m_sum, acc[WIDTH-1:1]};

        // Restoring divide step.
        shifted  = {rem, acc[WIDTH-1]};
        take     = (shifted >= {1'b0, mag_y});
        rem_next = take ? WIDTH'(shifted - {1'b0, mag_y}) : shifted[WIDTH-1:0];
        acc_div  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], take};

        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rmd  = neg_r ? -rem : rem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            div0   <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            mag_x  <= '0;
            mag_y  <= '0;
            acc    <= '0;
            rem    <= '0;
        end else begin
            done <= 1'b0;
            case (st)
                IDLE: begin
                    if (wr_hi) hi <= wdata;
                    if (wr_lo) lo <= wdata;
                    if (start) begin
                        busy   <= 1'b1;
                        is_div <= op[1];
                        neg_q  <= x_neg ^ y_neg;
                        neg_r  <= x_neg;
                        mag_y  <= y_abs;
                        rem    <= '0;
                        cnt    <= CW'(WIDTH - 1);
                        acc    <= op[1] ? {{WIDTH{1'b0}}, x_abs}
                                        : {{WIDTH{1'b0}}, y_abs};
                        if (op[1] && (y == '0)) begin
                            div0  <= 1'b1;
                            mag_x <= x;
                            st    <= FIX;
                        end else begin
                            div0  <= 1'b0;
                            mag_x <= x_abs;
                            st    <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (is_div) begin
                        acc <= acc_div;
                        rem <= rem_next;
                    end else begin
                        acc <= acc_mul;
                    end
                    if (cnt == '0) st <= FIX;
                    else           cnt <= cnt - 1'b1;
                end
                FIX: begin
                    if (div0) begin
                        hi <= mag_x;
                        lo <= '1;
                    end else if (is_div) begin
                        hi <= rmd;
                        lo <= quo;
                    end else begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end
                    done <= 1'b1;
                    busy <= 1'b0;
                    st   <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: directed vectors with hand-computed results for
// muldiv_hilo, including cycle-exact latency, MTHI/MTLO and reset abort.
module tb_muldiv_hilo;

    logic        clk = 1'b0;
    logic        rst, start, wr_hi, wr_lo;
    logic [1:0]  op;
    logic [31:0] x, y, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    muldiv_hilo #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .x     (x),
        .y     (y),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and follow it for exactly lat cycles.
    // disturb: in cycle 5 pulse start/wr_hi/wr_lo, which must all be ignored.
    // wrh: assert wr_hi with wd alongside start.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] eh, input logic [31:0] el,
                          input bit disturb, input bit wrh, input logic [31:0] wd);
        logic [31:0] h1, l1;
        int nb, nd, ns;
        op = o; x = a; y = b; start = 1'b1; wr_hi = wrh; wdata = wd;
        tick();
        start = 1'b0; wr_hi = 1'b0;
        x = 32'hA5A5_A5A5; y = 32'h5A5A_5A5A;
        if (wrh) chk({tag, "/mthi_with_start"}, {32'h0, hi}, {32'h0, wd});
        h1 = hi; l1 = lo;
        nb = 0; nd = 0; ns = 0;
        for (int c = 1; c < lat; c++) begin
            if (!busy) nb++;
            if (done) nd++;
            if (hi !== h1 || lo !== l1) ns++;
            if (disturb && c == 5) begin
                start = 1'b1; op = 2'b11; x = 32'd1; y = 32'd1;
                wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            tick();
            if (disturb && c == 5) begin
                start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
            end
        end
        chk({tag, "/busy_during"}, 64'(nb), 64'd0);
        chk({tag, "/early_done"}, 64'(nd), 64'd0);
        chk({tag, "/hilo_stable"}, 64'(ns), 64'd0);
        chk({tag, "/done"}, {63'h0, done}, 64'd1);
        chk({tag, "/busy_end"}, {63'h0, busy}, 64'd0);
        chk({tag, "/hi"}, {32'h0, hi}, {32'h0, eh});
        chk({tag, "/lo"}, {32'h0, lo}, {32'h0, el});
        tick();
        chk({tag, "/done_pulse"}, {63'h0, done}, 64'd0);
    endtask

    initial begin
        int nd;
        rst = 1'b1; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        op = 2'b00; x = '0; y = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst/busy", {63'h0, busy}, 64'd0);
        chk("rst/done", {63'h0, done}, 64'd0);
        chk("rst/hi", {32'h0, hi}, 64'd0);
        chk("rst/lo", {32'h0, lo}, 64'd0);

        // MTHI alone, then MTHI+MTLO together
        wr_hi = 1'b1; wdata = 32'h0000_1234;
        tick();
        wr_hi = 1'b0;
        chk("mthi/hi", {32'h0, hi}, 64'h1234);
        chk("mthi/lo", {32'h0, lo}, 64'h0);
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h0000_ABCD;
        tick();
        wr_hi = 1'b0; wr_lo = 1'b0;
        chk("mtboth/hi", {32'h0, hi}, 64'hABCD);
        chk("mtboth/lo", {32'h0, lo}, 64'hABCD);

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 32'h0);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 34,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 32'h0);
        run_op("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 34,
               32'h4000_0000, 32'h0, 1'b0, 1'b0, 32'h0);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 34,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'h0);
        run_op("divu", 2'b11, 32'd100, 32'd7, 34,
               32'd2, 32'd14, 1'b0, 1'b0, 32'h0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 34,
               32'h0, 32'h8000_0000, 1'b0, 1'b0, 32'h0);
        run_op("divu_zero", 2'b11, 32'd5, 32'd0, 2,
               32'd5, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
        run_op("div_zero_neg", 2'b10, 32'hFFFF_FFF7, 32'd0, 2,
               32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
        // start/wr_* while busy ignored; result unaffected
        run_op("busy_ignore", 2'b00, 32'hFFFF_FFFD, 32'd7, 34,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1, 1'b0, 32'h0);
        // MTHI in the start cycle is visible, then overwritten by the result
        run_op("start_mthi", 2'b01, 32'd3, 32'd5, 34,
               32'd0, 32'd15, 1'b0, 1'b1, 32'h0000_0077);

        // Reset in cycle 10 of a MULT aborts it
        op = 2'b00; x = 32'd12345; y = 32'hFFFF_FFF7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort/busy", {63'h0, busy}, 64'd0);
        chk("abort/done", {63'h0, done}, 64'd0);
        chk("abort/hi", {32'h0, hi}, 64'd0);
        chk("abort/lo", {32'h0, lo}, 64'd0);
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) nd++;
            tick();
        end
        chk("abort/no_result", 64'(nd), 64'd0);
        run_op("after_abort", 2'b01, 32'd6, 32'd7, 34,
               32'd0, 32'd42, 1'b0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
